// File: rtl/switch_ingress_buffer.sv
// Store-and-forward ingress buffer: only complete packets reach the switch port; overflowing or restarted packets are dropped whole.
// Optional drop counter port and logic enabled by defining SWITCH_INGRESS_DROP_CNT_EN.
module switch_ingress_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wrValid,
    input  logic [DATA_W-1:0]        wrData,
    input  logic                     wrSop,
    input  logic                     wrEop,
    input  logic                     stall,
    output logic [DATA_W-1:0]        outData,
    output logic                     outSop,
    output logic                     outEop,
    output logic                     outValid,
    output logic [$clog2(DEPTH):0]   pktCount
`ifdef SWITCH_INGRESS_DROP_CNT_EN
    ,
    output logic [15:0]              dropCount
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {W_IDLE, W_WRITE, W_DISCARD} wr_state_t;
    typedef enum logic       {R_IDLE, R_SEND} rd_state_t;

    wr_state_t          wr_state, wr_state_next;
    rd_state_t          rd_state, rd_state_next;
    logic [PW-1:0]      wr_ptr, wr_ptr_next, commit_ptr, commit_ptr_next, rd_ptr;
    logic [PW-1:0]      wr_addr;
    logic               mem_we, commit, drop, full;
    logic               load, go_idle, eop_done;
    logic [DATA_W+1:0]  mem [DEPTH];
    logic [DATA_W+1:0]  head;

    assign full = (wr_ptr - rd_ptr) == PW'(DEPTH);
    assign head = mem[rd_ptr[AW-1:0]];

    // Write side: decide where (and whether) the incoming word lands.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        wr_state_next   = wr_state;
        wr_ptr_next     = wr_ptr;
        commit_ptr_next = commit_ptr;
        wr_addr         = wr_ptr;
        mem_we          = 1'b0;
        commit          = 1'b0;
        drop            = 1'b0;
        if (wrValid) begin
            if (full) begin
                wr_ptr_next   = commit_ptr;
                drop          = wrSop || (wr_state == W_WRITE);
                wr_state_next = wrEop ? W_IDLE : W_DISCARD;
            end else begin
                case (wr_state)
                    W_WRITE: begin
                        mem_we = 1'b1;
                        if (wrSop) begin
                            wr_addr = commit_ptr;
                            drop    = 1'b1;
                        end
                        commit        = wrEop;
                        wr_state_next = wrEop ? W_IDLE : W_WRITE;
                    end
                    default: begin
                        if (wrSop) begin
                            mem_we        = 1'b1;
                            commit        = wrEop;
                            wr_state_next = wrEop ? W_IDLE : W_WRITE;
                        end else if (wrEop) begin
                            wr_state_next = W_IDLE;
                        end
                    end
                endcase
                if (mem_we) wr_ptr_next = wr_addr + PW'(1);
                if (commit) commit_ptr_next = wr_addr + PW'(1);
            end
        end
    end

    // NOTE: storage array has no reset; only committed entries are ever read.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_addr[AW-1:0]] <= {wrSop, wrEop, wrData};
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state   <= W_IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
        end else begin
            wr_state   <= wr_state_next;
            wr_ptr     <= wr_ptr_next;
            commit_ptr <= commit_ptr_next;
        end
    end

    // Read side: only packets already counted are loaded, so a word is never read on its write edge.
    always_comb begin
        rd_state_next = rd_state;
        load          = 1'b0;
        go_idle       = 1'b0;
        eop_done      = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (pktCount != '0) begin
                    load          = 1'b1;
                    rd_state_next = R_SEND;
                end
            end
            default: begin
                if (outValid && !stall) begin
                    if (outEop) begin
                        eop_done = 1'b1;
                        if (pktCount > PW'(1)) begin
                            load = 1'b1;
                        end else begin
                            go_idle       = 1'b1;
                            rd_state_next = R_IDLE;
                        end
                    end else begin
                        load = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state <= R_IDLE;
            rd_ptr   <= '0;
            outData  <= '0;
            outSop   <= 1'b0;
            outEop   <= 1'b0;
            outValid <= 1'b0;
            pktCount <= '0;
        end else begin
            rd_state <= rd_state_next;
            if (load) begin
                {outSop, outEop, outData} <= head;
                outValid <= 1'b1;
                rd_ptr   <= rd_ptr + PW'(1);
            end else if (go_idle) begin
                outData  <= '0;
                outSop   <= 1'b0;
                outEop   <= 1'b0;
                outValid <= 1'b0;
            end
            case ({commit, eop_done})
                2'b10:   pktCount <= pktCount + PW'(1);
                2'b01:   pktCount <= pktCount - PW'(1);
                default: pktCount <= pktCount;
            endcase
        end
    end

`ifdef SWITCH_INGRESS_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dropCount <= '0;
        end else if (drop && dropCount != 16'hFFFF) begin
            dropCount <= dropCount + 16'd1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule
